fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pc_unit_pkg.sv | 22 ++
 rtl/fetch_pc_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared RV32I fetch-side types: machine word, branch-predictor bundle and fetch FSM states.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    logic      prediction;
    rv32i_word brp_target;
    rv32i_word brp_alt;
    logic      mp_valid;
    logic      mispredicted;
  } rv32i_brp_word;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam rv32i_word RESET_PC_DEFAULT = 32'h4000_0060;

endpackage

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: owns the fetch PC, issues one imem read at a time and
// picks the next PC from redirect, stall, predictor target or PC+4.
module fetch_pc_unit
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_in,
  input  logic          imem_resp,
  input  logic [31:0]   imem_rdata,
  input  rv32i_brp_word brp_if,
  input  rv32i_brp_word brp_ex,
  output logic          imem_read,
  output logic [31:0]   imem_address,
  output logic [31:0]   pc_if,
  output logic [31:0]   instr_if,
  output logic          if_valid,
  output logic [31:0]   c_fetched,
  output logic [31:0]   c_redirect
);

  fetch_state_t state_q, state_d;
  rv32i_word    pc_q, pc_d;
  rv32i_word    hold_instr_q, hold_instr_d;
  rv32i_word    redir_pc_q, redir_pc_d;
  rv32i_word    c_fetched_q, c_fetched_d;
  rv32i_word    c_redirect_q, c_redirect_d;

  logic      redirect;
  rv32i_word redir_pc;
  rv32i_word next_pc;
  logic      unused_brp;

  assign redirect   = brp_ex.mp_valid && brp_ex.mispredicted;
  assign redir_pc   = brp_ex.brp_alt;
  assign next_pc    = brp_if.prediction ? brp_if.brp_target : pc_q + 32'd4;
  assign unused_brp = ^{brp_if.brp_alt, brp_if.mp_valid, brp_if.mispredicted,
                        brp_ex.prediction, brp_ex.brp_target};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      redir_pc_q   <= '0;
      c_fetched_q  <= '0;
      c_redirect_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      redir_pc_q   <= redir_pc_d;
      c_fetched_q  <= c_fetched_d;
      c_redirect_q <= c_redirect_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    redir_pc_d   = redir_pc_q;
    c_fetched_d  = c_fetched_q;
    c_redirect_d = c_redirect_q;
    unique case (state_q)
      FETCH: begin
        if (imem_resp) begin
          if (redirect) begin
            pc_d         = redir_pc;
            c_redirect_d = c_redirect_q + 32'd1;
          end else if (!stall_in) begin
            pc_d        = next_pc;
            c_fetched_d = c_fetched_q + 32'd1;
          end else begin
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          redir_pc_d   = redir_pc;
          c_redirect_d = c_redirect_q + 32'd1;
          state_d      = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d         = redir_pc;
          c_redirect_d = c_redirect_q + 32'd1;
          state_d      = FETCH;
        end else if (!stall_in) begin
          pc_d        = next_pc;
          c_fetched_d = c_fetched_q + 32'd1;
          state_d     = FETCH;
        end
      end
      DRAIN: begin
        // The youngest redirect wins, even in the cycle the stale word returns.
        if (redirect) begin
          redir_pc_d   = redir_pc;
          c_redirect_d = c_redirect_q + 32'd1;
        end
        if (imem_resp) begin
          pc_d    = redirect ? redir_pc : redir_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_read    = 1'b0;
    imem_address = '0;
    pc_if        = '0;
    instr_if     = '0;
    if_valid     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          imem_read    = 1'b1;
          imem_address = pc_q;
          pc_if        = pc_q;
          instr_if     = imem_rdata;
          if_valid     = imem_resp;
        end
        HOLD: begin
          pc_if    = pc_q;
          instr_if = hold_instr_q;
          if_valid = 1'b1;
        end
        DRAIN: begin
          imem_read    = 1'b1;
          imem_address = pc_q;
          pc_if        = pc_q;
        end
        default: ;
      endcase
    end
  end

  assign c_fetched  = c_fetched_q;
  assign c_redirect = c_redirect_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;
  import rv32i_types::*;

  logic          clk;
  logic          rst;
  logic          stall_in;
  logic          imem_resp;
  logic [31:0]   imem_rdata;
  rv32i_brp_word brp_if;
  rv32i_brp_word brp_ex;
  logic          imem_read;
  logic [31:0]   imem_address;
  logic [31:0]   pc_if;
  logic [31:0]   instr_if;
  logic          if_valid;
  logic [31:0]   c_fetched;
  logic [31:0]   c_redirect;

  int unsigned n_checks;
  int unsigned n_fail;

  fetch_pc_unit #(.RESET_PC(32'h4000_0060)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_in     (stall_in),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .brp_if       (brp_if),
    .brp_ex       (brp_ex),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .pc_if        (pc_if),
    .instr_if     (instr_if),
    .if_valid     (if_valid),
    .c_fetched    (c_fetched),
    .c_redirect   (c_redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redirect(input logic on, input logic [31:0] alt);
    brp_ex              = '0;
    brp_ex.mp_valid     = on;
    brp_ex.mispredicted = on;
    brp_ex.brp_alt      = alt;
  endtask

  task automatic set_pred(input logic on, input logic [31:0] tgt);
    brp_if            = '0;
    brp_if.prediction = on;
    brp_if.brp_target = tgt;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    stall_in   = 1'b0;
    imem_resp  = 1'b1;
    imem_rdata = 32'h0000_0013;
    set_pred(1'b0, 32'h0);
    set_redirect(1'b0, 32'h0);

    // Reset: outputs forced to zero even with a response present
    tick(); tick();
    #1;
    check("rst_read",  {31'b0, imem_read}, 32'd0);
    check("rst_valid", {31'b0, if_valid},  32'd0);
    check("rst_addr",  imem_address, 32'h0);
    check("rst_instr", instr_if, 32'h0);
    check("rst_pc",    pc_if, 32'h0);
    check("rst_cf",    c_fetched, 32'd0);
    check("rst_cr",    c_redirect, 32'd0);

    // Back-to-back single-cycle fetch
    tick(); rst = 1'b0; #1;
    check("a_read",  {31'b0, imem_read}, 32'd1);
    check("a_addr",  imem_address, 32'h4000_0060);
    check("a_valid", {31'b0, if_valid}, 32'd1);
    check("a_pcif",  pc_if, 32'h4000_0060);
    check("a_instr", instr_if, 32'h0000_0013);
    tick(); #1;
    check("b_addr",  imem_address, 32'h4000_0064);
    check("b_valid", {31'b0, if_valid}, 32'd1);
    tick(); #1;
    check("c_addr",  imem_address, 32'h4000_0068);
    check("c_valid", {31'b0, if_valid}, 32'd1);
    tick(); imem_resp = 1'b0; #1;
    check("d_cf",    c_fetched, 32'd3);
    check("d_addr",  imem_address, 32'h4000_006C);
    check("d_novld", {31'b0, if_valid}, 32'd0);

    // Predicted-taken word at 6C redirects fetch to the target
    tick(); imem_resp = 1'b1; set_pred(1'b1, 32'h4000_0100); #1;
    check("d2_addr", imem_address, 32'h4000_006C);
    tick(); set_pred(1'b0, 32'h0); stall_in = 1'b1; imem_rdata = 32'hAAAA_0001; #1;
    check("pred_addr", imem_address, 32'h4000_0100);
    check("e_instr",   instr_if, 32'hAAAA_0001);
    check("e_valid",   {31'b0, if_valid}, 32'd1);

    // Stall held for three cycles: HOLD presents the latched word
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_rdata = 32'hDEAD_0000 + i;
      imem_resp  = 1'b0;
      if (i == 2) stall_in = 1'b0;
      #1;
      check("hold_read",  {31'b0, imem_read}, 32'd0);
      check("hold_instr", instr_if, 32'hAAAA_0001);
      check("hold_pc",    pc_if, 32'h4000_0100);
      check("hold_valid", {31'b0, if_valid}, 32'd1);
      check("hold_cf",    c_fetched, 32'd4);
    end

    // Redirect while the request is outstanding: drain the old access
    tick(); set_redirect(1'b1, 32'h4000_0200); #1;
    check("i_addr",  imem_address, 32'h4000_0104);
    check("i_cf",    c_fetched, 32'd5);
    tick(); set_redirect(1'b0, 32'h0); #1;
    check("drn_read",  {31'b0, imem_read}, 32'd1);
    check("drn_addr",  imem_address, 32'h4000_0104);
    check("drn_valid", {31'b0, if_valid}, 32'd0);
    check("drn_cr",    c_redirect, 32'd1);
    tick(); imem_resp = 1'b1; imem_rdata = 32'hBBBB_0000; #1;
    check("drn_rsp_valid", {31'b0, if_valid}, 32'd0);
    check("drn_rsp_addr",  imem_address, 32'h4000_0104);

    // Redirect coinciding with response and stall: no HOLD, word not counted
    tick(); stall_in = 1'b1; set_redirect(1'b1, 32'h4000_0300); #1;
    check("l_addr", imem_address, 32'h4000_0200);
    check("l_cr",   c_redirect, 32'd1);
    tick(); stall_in = 1'b0; imem_resp = 1'b0; set_redirect(1'b1, 32'h4000_0400); #1;
    check("m_addr", imem_address, 32'h4000_0300);
    check("m_read", {31'b0, imem_read}, 32'd1);
    check("m_cf",   c_fetched, 32'd5);
    check("m_cr",   c_redirect, 32'd2);

    // Reset during DRAIN abandons the request
    tick(); set_redirect(1'b0, 32'h0); rst = 1'b1; #1;
    check("rd_read",  {31'b0, imem_read}, 32'd0);
    check("rd_addr",  imem_address, 32'h0);
    check("rd_valid", {31'b0, if_valid}, 32'd0);
    check("rd_cr",    c_redirect, 32'd3);
    tick(); rst = 1'b0; imem_resp = 1'b1; imem_rdata = 32'h0000_0013;
    set_pred(1'b1, 32'h4000_0100); #1;
    check("o_addr", imem_address, 32'h4000_0060);
    check("o_read", {31'b0, imem_read}, 32'd1);
    check("o_cr",   c_redirect, 32'd0);
    check("o_cf",   c_fetched, 32'd0);
    tick(); set_pred(1'b0, 32'h0); imem_resp = 1'b0; set_redirect(1'b1, 32'h4000_0500); #1;
    check("p_addr", imem_address, 32'h4000_0100);
    check("p_cf",   c_fetched, 32'd1);

    // Second redirect in DRAIN overrides the first
    tick(); set_redirect(1'b1, 32'h4000_0600); #1;
    check("q_addr", imem_address, 32'h4000_0100);
    tick(); set_redirect(1'b0, 32'h0); imem_resp = 1'b1; #1;
    check("r_valid", {31'b0, if_valid}, 32'd0);
    tick(); #1;
    check("s_addr", imem_address, 32'h4000_0600);
    check("s_cf",   c_fetched, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
